// File: rtl/axi3_pkg.sv
// rtl/axi3_pkg.sv - AXI3 burst/response encodings and slave FSM state types
package axi3_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  // WRAP and the reserved encoding both carry bit 1 set; neither is supported.
  function automatic logic burst_bad(input logic [1:0] burst);
    return burst[1];
  endfunction

endpackage

// File: rtl/axi3_slave_ram_mem.sv
// rtl/axi3_slave_ram_mem.sv - simple dual-port 32-bit RAM, byte-enable write, registered read-first read
module axi3_slave_ram_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [3:0]        wbe,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi3_slave_ram.sv
// rtl/axi3_slave_ram.sv - AXI3 slave with internal word RAM, one outstanding write and one outstanding read
module axi3_slave_ram
  import axi3_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int ID_W   = 6
) (
  input  logic            AXI_clk,
  input  logic            rst,
  input  logic [31:0]     AXI_awaddr,
  input  logic [3:0]      AXI_awlen,
  input  logic [2:0]      AXI_awsize,
  input  logic [1:0]      AXI_awburst,
  input  logic [ID_W-1:0] AXI_awid,
  input  logic            AXI_awvalid,
  output logic            AXI_awready,
  input  logic [31:0]     AXI_wdata,
  input  logic [3:0]      AXI_wstrb,
  input  logic            AXI_wlast,
  input  logic [ID_W-1:0] AXI_wid,
  input  logic            AXI_wvalid,
  output logic            AXI_wready,
  output logic [ID_W-1:0] AXI_bid,
  output logic [1:0]      AXI_bresp,
  output logic            AXI_bvalid,
  input  logic            AXI_bready,
  input  logic [31:0]     AXI_araddr,
  input  logic [3:0]      AXI_arlen,
  input  logic [2:0]      AXI_arsize,
  input  logic [1:0]      AXI_arburst,
  input  logic [ID_W-1:0] AXI_arid,
  input  logic            AXI_arvalid,
  output logic            AXI_arready,
  output logic [31:0]     AXI_rdata,
  output logic [ID_W-1:0] AXI_rid,
  output logic [1:0]      AXI_rresp,
  output logic            AXI_rlast,
  output logic            AXI_rvalid,
  input  logic            AXI_rready,
  output logic [31:0]     wcnt,
  output logic [31:0]     rcnt
);

  wstate_t           wstate;
  logic [ADDR_W-1:0] widx;
  logic [3:0]        wleft;
  logic [1:0]        wburst;
  logic              wflag;
  logic              w_hs;
  logic              w_final;

  rstate_t           rstate;
  logic [ADDR_W-1:0] ridx;
  logic [ADDR_W-1:0] ridx_next;
  logic [3:0]        rleft;
  logic [1:0]        rburst;
  logic              r_hs;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_q;

  logic unused_ok;
  assign unused_ok = ^{AXI_awsize, AXI_arsize, AXI_wid,
                       AXI_awaddr[31:ADDR_W+2], AXI_awaddr[1:0],
                       AXI_araddr[31:ADDR_W+2], AXI_araddr[1:0]};

  assign w_hs    = AXI_wvalid & AXI_wready;
  assign w_final = (wleft == 4'd0);

  always_ff @(posedge AXI_clk or posedge rst) begin
    if (rst) begin
      wstate      <= W_IDLE;
      AXI_awready <= 1'b0;
      AXI_wready  <= 1'b0;
      AXI_bvalid  <= 1'b0;
      AXI_bresp   <= RESP_OKAY;
      AXI_bid     <= '0;
      widx        <= '0;
      wleft       <= '0;
      wburst      <= BURST_FIXED;
      wflag       <= 1'b0;
      wcnt        <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          AXI_awready <= 1'b1;
          if (AXI_awvalid && AXI_awready) begin
            AXI_awready <= 1'b0;
            AXI_wready  <= 1'b1;
            widx        <= AXI_awaddr[ADDR_W+1:2];
            wleft       <= AXI_awlen;
            wburst      <= AXI_awburst;
            AXI_bid     <= AXI_awid;
            wflag       <= 1'b0;
            wstate      <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (wburst == BURST_INCR) widx <= widx + 1'b1;
            wleft <= wleft - 4'd1;
            // The beat counter, not wlast, ends the burst; a disagreeing wlast only flags it.
            if (w_final) begin
              AXI_wready <= 1'b0;
              AXI_bvalid <= 1'b1;
              AXI_bresp  <= (wflag || !AXI_wlast || burst_bad(wburst)) ? RESP_SLVERR : RESP_OKAY;
              wstate     <= W_RESP;
            end else if (AXI_wlast) begin
              wflag <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (AXI_bready) begin
            AXI_bvalid  <= 1'b0;
            AXI_awready <= 1'b1;
            wcnt        <= wcnt + 32'd1;
            wstate      <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  assign r_hs      = AXI_rvalid & AXI_rready;
  assign ridx_next = (rburst == BURST_INCR) ? ridx + 1'b1 : ridx;
  // Prefetch the next word on a non-last handshake so beats stream one per cycle.
  assign mem_re    = (rstate == R_FETCH) | (r_hs & ~AXI_rlast);
  assign mem_raddr = (rstate == R_FETCH) ? ridx : ridx_next;

  always_ff @(posedge AXI_clk or posedge rst) begin
    if (rst) begin
      rstate      <= R_IDLE;
      AXI_arready <= 1'b0;
      AXI_rvalid  <= 1'b0;
      AXI_rlast   <= 1'b0;
      AXI_rresp   <= RESP_OKAY;
      AXI_rid     <= '0;
      ridx        <= '0;
      rleft       <= '0;
      rburst      <= BURST_FIXED;
      rcnt        <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          AXI_arready <= 1'b1;
          if (AXI_arvalid && AXI_arready) begin
            AXI_arready <= 1'b0;
            ridx        <= AXI_araddr[ADDR_W+1:2];
            rleft       <= AXI_arlen;
            rburst      <= AXI_arburst;
            AXI_rid     <= AXI_arid;
            AXI_rresp   <= burst_bad(AXI_arburst) ? RESP_SLVERR : RESP_OKAY;
            rstate      <= R_FETCH;
          end
        end
        R_FETCH: begin
          AXI_rvalid <= 1'b1;
          AXI_rlast  <= (rleft == 4'd0);
          rstate     <= R_DATA;
        end
        R_DATA: begin
          if (r_hs) begin
            if (AXI_rlast) begin
              AXI_rvalid  <= 1'b0;
              AXI_rlast   <= 1'b0;
              AXI_arready <= 1'b1;
              rcnt        <= rcnt + 32'd1;
              rstate      <= R_IDLE;
            end else begin
              ridx      <= ridx_next;
              rleft     <= rleft - 4'd1;
              AXI_rlast <= (rleft == 4'd1);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign AXI_rdata = (AXI_rresp == RESP_SLVERR) ? 32'd0 : mem_q;

  axi3_slave_ram_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (AXI_clk),
    .rst   (rst),
    .we    (w_hs & ~burst_bad(wburst)),
    .wbe   (AXI_wstrb),
    .waddr (widx),
    .wdata (AXI_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_q)
  );

endmodule
